// File: rtl/pheap_issue_scheduler.sv
// Level-1 front end for the pipelined heap: round-robin grant of two requesters, occupancy guard, spaced issue.
// Legal op: lvl_start at T+1, resp at T+3; rejected op: resp at T+1. One op in flight; ready held low until idle and gap expired.

package pheapTypes;
    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_LEQ = 2'd1,
        OP_DEQ = 2'd2
    } opcode_t;
endpackage

module pheap_issue_scheduler
    import pheapTypes::*;
#(
    parameter int LEVELS    = 4,
    parameter int ISSUE_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a_valid,
    input  opcode_t           req_a_op,
    input  logic [31:0]       req_a_data,
    output logic              req_a_ready,
    input  logic              req_b_valid,
    input  opcode_t           req_b_op,
    input  logic [31:0]       req_b_data,
    output logic              req_b_ready,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [31:0]       resp_data,
    output logic              resp_err,
    output logic              lvl_start,
    output opcode_t           lvl_op,
    output logic [31:0]       lvl_in,
    input  logic [31:0]       lvl_out,
    output logic [LEVELS-1:0] count,
    output logic              full,
    output logic              empty
);

    localparam int              GW       = $clog2(ISSUE_GAP) + 1;
    localparam logic [GW-1:0]   GAP_LOAD = GW'(ISSUE_GAP - 1);
    localparam logic [LEVELS-1:0] CAP    = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP,
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_gap;
    logic              r_rr;
    opcode_t           r_op;
    logic [31:0]       r_data;
    logic              r_id;
    logic              r_err;
    logic [31:0]       r_res;
    logic [LEVELS-1:0] r_count;

    logic              w_open;
    logic              w_grant_b;
    logic              w_hs;
    logic              w_legal;
    opcode_t           w_op;
    logic [31:0]       w_data;

    // rst gates ready so no handshake is ever reported while reset is held
    assign w_open = (r_state == S_IDLE) && (r_gap == '0) && !rst;

    always_comb begin
        w_grant_b = 1'b0;
        if (req_a_valid && req_b_valid) begin
            w_grant_b = r_rr;
        end else if (req_b_valid) begin
            w_grant_b = 1'b1;
        end
    end

    assign w_hs        = w_open && (req_a_valid || req_b_valid);
    assign req_a_ready = w_open && req_a_valid && !w_grant_b;
    assign req_b_ready = w_open && req_b_valid && w_grant_b;
    assign w_op        = w_grant_b ? req_b_op   : req_a_op;
    assign w_data      = w_grant_b ? req_b_data : req_a_data;

    assign count   = r_count;
    assign full    = (r_count == CAP);
    assign empty   = (r_count == '0);
    assign w_legal = ((w_op == OP_LEQ) && !full) || ((w_op == OP_DEQ) && !empty);

    always_comb begin
        w_state_nxt = r_state;
        resp_valid  = 1'b0;
        resp_id     = 1'b0;
        resp_data   = '0;
        resp_err    = 1'b0;
        lvl_start   = 1'b0;
        lvl_op      = OP_NOP;
        lvl_in      = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = w_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                lvl_start   = 1'b1;
                lvl_op      = r_op;
                lvl_in      = r_data;
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                resp_id     = r_id;
                resp_data   = r_res;
                resp_err    = r_err;
                w_state_nxt = (r_gap != '0) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                // counter hits zero on this edge, so IDLE opens with a clear gap
                if (r_gap <= GW'(1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gap   <= '0;
            r_rr    <= 1'b0;
            r_op    <= OP_NOP;
            r_data  <= '0;
            r_id    <= 1'b0;
            r_err   <= 1'b0;
            r_res   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == S_ISSUE) begin
                r_gap <= GAP_LOAD;
            end else if (r_gap != '0) begin
                r_gap <= r_gap - GW'(1);
            end

            if (w_hs) begin
                r_op   <= w_op;
                r_data <= w_data;
                r_id   <= w_grant_b;
                r_err  <= !w_legal;
                r_res  <= '0;
                if (req_a_valid && req_b_valid) begin
                    r_rr <= ~w_grant_b;
                end
            end

            if ((r_state == S_CAPTURE) && (r_op == OP_DEQ)) begin
                r_res <= lvl_out;
            end

            if ((r_state == S_RESP) && !r_err) begin
                if (r_op == OP_LEQ) begin
                    r_count <= r_count + 1'b1;
                end else if (r_op == OP_DEQ) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pheap_issue_scheduler.sv
// Bench for pheap_issue_scheduler: directed requests, queued expectations checked by response monitors.
module tb_pheap_issue_scheduler;
    import pheapTypes::*;

    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_v, b_v, a_r, b_r;
    opcode_t     a_op, b_op;
    logic [31:0] a_d, b_d;
    logic        rv, rid, rerr;
    logic [31:0] rdat;
    logic        ls;
    opcode_t     lop;
    logic [31:0] lin, lout;
    logic [3:0]  cnt;
    logic        full, empty;

    logic        s_v, s_r, s_bv, s_br;
    opcode_t     s_op, s_bop, s_lop;
    logic [31:0] s_d, s_bd, s_lin, s_lout;
    logic        s_rv, s_rid, s_rerr, s_ls, s_full, s_empty;
    logic [31:0] s_rdat;
    logic [1:0]  s_cnt;

    pheap_issue_scheduler #(.LEVELS(4), .ISSUE_GAP(GAP)) dut (
        .clk(clk), .rst(rst),
        .req_a_valid(a_v), .req_a_op(a_op), .req_a_data(a_d), .req_a_ready(a_r),
        .req_b_valid(b_v), .req_b_op(b_op), .req_b_data(b_d), .req_b_ready(b_r),
        .resp_valid(rv), .resp_id(rid), .resp_data(rdat), .resp_err(rerr),
        .lvl_start(ls), .lvl_op(lop), .lvl_in(lin), .lvl_out(lout),
        .count(cnt), .full(full), .empty(empty)
    );

    pheap_issue_scheduler #(.LEVELS(2), .ISSUE_GAP(GAP)) dut_small (
        .clk(clk), .rst(rst),
        .req_a_valid(s_v), .req_a_op(s_op), .req_a_data(s_d), .req_a_ready(s_r),
        .req_b_valid(s_bv), .req_b_op(s_bop), .req_b_data(s_bd), .req_b_ready(s_br),
        .resp_valid(s_rv), .resp_id(s_rid), .resp_data(s_rdat), .resp_err(s_rerr),
        .lvl_start(s_ls), .lvl_op(s_lop), .lvl_in(s_lin), .lvl_out(s_lout),
        .count(s_cnt), .full(s_full), .empty(s_empty)
    );

    assign s_bv   = 1'b0;
    assign s_bop  = OP_NOP;
    assign s_bd   = 32'h0;
    assign s_lout = 32'h0;

    typedef struct packed {
        logic        id;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t q_main[$];
    exp_t q_small[$];
    int   grant_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_resp_cyc = -1;
    int   last_ls_cyc = -1;
    int   prev_ls = -1;
    int   ls_count = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Level-1 stand-in: a max-heap of whatever was inserted, answering DEQ one cycle after lvl_start
    logic [31:0] heap_m[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            heap_m.delete();
            lout <= 32'h0;
        end else if (ls) begin
            if (lop == OP_LEQ) begin
                heap_m.push_back(lin);
            end else if (lop == OP_DEQ) begin
                int mi;
                mi = 0;
                if (heap_m.size() == 0) begin
                    lout <= 32'h0;
                end else begin
                    for (int i = 1; i < heap_m.size(); i++)
                        if (heap_m[i] > heap_m[mi]) mi = i;
                    lout <= heap_m[mi];
                    heap_m.delete(mi);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_ls = -1;
            if (rv) check("resp_during_reset", rv, 0);
        end else begin
            if (rv) begin
                last_resp_cyc = cyc;
                check("resp_expected", q_main.size() > 0, 1);
                if (q_main.size() > 0) begin
                    e = q_main.pop_front();
                    check("resp_id", rid, e.id);
                    check("resp_err", rerr, e.err);
                    check("resp_data", rdat, e.data);
                end
            end
            if (ls) begin
                ls_count++;
                last_ls_cyc = cyc;
                if (prev_ls >= 0) check("issue_spacing_ok", (cyc - prev_ls) >= GAP, 1);
                prev_ls = cyc;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && s_rv) begin
            check("small_resp_expected", q_small.size() > 0, 1);
            if (q_small.size() > 0) begin
                e = q_small.pop_front();
                check("small_resp_err", s_rerr, e.err);
                check("small_resp_data", s_rdat, e.data);
            end
        end
    end

    task automatic set_req(input int who, input logic v, input opcode_t op, input logic [31:0] d);
        case (who)
            0: begin a_v = v; a_op = op; a_d = d; end
            1: begin b_v = v; b_op = op; b_d = d; end
            default: begin s_v = v; s_op = op; s_d = d; end
        endcase
    endtask

    function automatic logic rdy(input int who);
        return (who == 0) ? a_r : (who == 1) ? b_r : s_r;
    endfunction

    task automatic do_req(input int who, input opcode_t op, input logic [31:0] d, input bit push,
                          input logic exp_err, input logic [31:0] exp_data, input bit hold,
                          output int hs_cyc);
        bit   got;
        exp_t e;
        got    = 1'b0;
        hs_cyc = -1;
        @(negedge clk);
        set_req(who, 1'b1, op, d);
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (rdy(who)) got = 1'b1;
            else @(negedge clk);
        end
        check("handshake", got, 1);
        if (got) begin
            hs_cyc = cyc;
            e.id   = (who == 1);
            e.err  = exp_err;
            e.data = exp_data;
            if (who < 2) grant_log.push_back(who);
            if (push) begin
                if (who == 2) q_small.push_back(e);
                else q_main.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!hold || !got) set_req(who, 1'b0, OP_NOP, 32'h0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (q_main.size() != 0 || q_small.size() != 0); i++) @(negedge clk);
        check("drain_queues_empty", q_main.size() + q_small.size(), 0);
        repeat (GAP + 2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, h2, ha, hb, n;
        rst = 1'b1;
        set_req(0, 1'b1, OP_LEQ, 32'h1);
        set_req(1, 1'b0, OP_NOP, 32'h0);
        set_req(2, 1'b0, OP_NOP, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready_a", a_r, 0);
        check("rst_resp_valid", rv, 0);
        check("rst_lvl_start", ls, 0);
        check("rst_lvl_op", lop, OP_NOP);
        check("rst_lvl_in", lin, 0);
        check("rst_count", cnt, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        set_req(0, 1'b0, OP_NOP, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_req(0, OP_LEQ, 32'h10, 1, 0, 32'h0, 0, h);
        do_req(0, OP_LEQ, 32'h30, 1, 0, 32'h0, 0, h);
        do_req(0, OP_LEQ, 32'h20, 1, 0, 32'h0, 0, h);
        drain();
        check("count_after_3_leq", cnt, 3);
        do_req(0, OP_DEQ, 32'h0, 1, 0, 32'h30, 0, h);
        drain();
        check("count_after_deq", cnt, 2);
        do_req(0, OP_DEQ, 32'h0, 1, 0, 32'h20, 0, h);
        do_req(0, OP_DEQ, 32'h0, 1, 0, 32'h10, 0, h);
        drain();
        check("count_drained", cnt, 0);
        check("empty_drained", empty, 1);

        n = ls_count;
        do_req(1, OP_DEQ, 32'h0, 1, 1, 32'h0, 0, h);
        do_req(1, OP_LEQ, 32'h7, 1, 0, 32'h0, 0, h2);
        check("err_resp_latency", last_resp_cyc - h, 1);
        check("err_no_lvl_start", ls_count, n);
        check("err_next_handshake", h2 - h, 2);
        drain();
        check("count_after_err_and_leq", cnt, 1);
        do_req(1, OP_DEQ, 32'h0, 1, 0, 32'h7, 0, h);
        drain();
        check("deq_lvl_start_latency", last_ls_cyc - h, 1);
        check("deq_resp_latency", last_resp_cyc - h, 3);
        check("count_after_b_deq", cnt, 0);

        do_req(2, OP_LEQ, 32'h1, 1, 0, 32'h0, 0, h);
        do_req(2, OP_LEQ, 32'h2, 1, 0, 32'h0, 0, h);
        do_req(2, OP_LEQ, 32'h3, 1, 0, 32'h0, 0, h);
        drain();
        check("small_full_at_cap", s_full, 1);
        do_req(2, OP_LEQ, 32'h5, 1, 1, 32'h0, 0, h);
        drain();
        check("small_full_kept", s_full, 1);
        check("small_count_kept", s_cnt, 3);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        grant_log.delete();
        fork
            begin
                do_req(0, OP_LEQ, 32'h41, 1, 0, 32'h0, 1, ha);
                do_req(0, OP_LEQ, 32'h42, 1, 0, 32'h0, 0, ha);
            end
            begin
                do_req(1, OP_LEQ, 32'h51, 1, 0, 32'h0, 1, hb);
                do_req(1, OP_LEQ, 32'h52, 1, 0, 32'h0, 0, hb);
            end
        join
        drain();
        check("grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            check("grant_0_is_a", grant_log[0], 0);
            check("grant_1_is_b", grant_log[1], 1);
            check("grant_2_is_a", grant_log[2], 0);
            check("grant_3_is_b", grant_log[3], 1);
        end
        check("count_after_contention", cnt, 4);

        do_req(0, OP_DEQ, 32'h0, 0, 0, 32'h0, 0, h);
        @(negedge clk);
        check("abort_issue_seen", ls, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_resp_valid", rv, 0);
        check("abort_lvl_start", ls, 0);
        check("abort_count", cnt, 0);
        check("abort_empty", empty, 1);
        check("abort_full", full, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        do_req(0, OP_LEQ, 32'h11, 1, 0, 32'h0, 0, h);
        drain();
        check("post_abort_leq_issue", last_ls_cyc - h, 1);
        check("post_abort_count", cnt, 1);
        do_req(0, OP_DEQ, 32'h0, 1, 0, 32'h11, 0, h);
        drain();
        check("final_count", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
